sig_gen: RTL and testbench
==========================

# sig_gen

Programmable square-wave generator for the oscilloscope's calibration and self-test output, and the transmit-side counterpart of the frequency/duty meter. It takes a target frequency in Hz and a duty cycle in percent, converts them to cycle counts on the 100 MHz system clock with a shared sequential divider, and drives a glitch-free square wave on `sign_out`. New settings take effect only at a period boundary, so the meter never sees a truncated period.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency, the dividend of the period computation.
- `CNT_W`, default 32: width of the period and high-time counters.
- `clk_100M`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `freq_set`, in, 28: requested frequency in Hz; sampled on an accepted `load`.
- `duty_set`, in, 7: requested duty cycle in percent, 0..100; sampled on an accepted `load`.
- `load`, in, 1: single-cycle request strobe.
- `sign_out`, out, 1: generated square wave, registered.
- `busy`, out, 1: high while a request is being computed or armed.
- `err`, out, 1: sticky flag for a rejected request; cleared by the next accepted valid load.
- `period`, out, CNT_W: period in clocks currently being generated; 0 means stopped.

## Operation
- The FSM has four states: IDLE, DIV_P, DIV_H and ARM.
- **IDLE**
  - `load` is accepted only in IDLE. Loads that arrive while `busy` is high are ignored.
  - A request is invalid if `freq_set` == 0, `freq_set` > CLK_HZ/2, or `duty_set` > 100.
  - Invalid request: set `err` = 1, leave generator settings unchanged, stay in IDLE.
  - Valid request: latch both inputs, clear `err`, set `busy`, go to DIV_P.
- **DIV_P**
  - Computes P = floor(CLK_HZ / freq) with a 32-iteration restoring divide.
  - Goes to DIV_H when done.
- **DIV_H**
  - Computes H = floor(P × duty / 100).
  - The product is 40 bits wide; the divide runs 40 iterations.
  - The divider is reused from DIV_P.
  - Goes to ARM when done.
- **ARM**
  - If the generator is stopped (`period` == 0), apply P and H immediately.
  - Otherwise wait until `cnt` == `period` − 1, then apply P and H on that same edge as `cnt` wraps to 0.
  - After applying, clear `busy` and return to IDLE.
- **Generator**
  - `cnt` runs from 0 to `period` − 1 and wraps.
  - `sign_out` is registered from (`cnt` < `high`).
  - duty 0 gives a constant low output; duty 100 gives H = P, a constant high output.
  - H == 0 with a nonzero duty (very small P) gives a constant low output; this is legal.
- **Reset** (asserted at any point, including mid-divide or during ARM):
  - `sign_out` = 0, `busy` = 0, `err` = 0, `period` = 0, `high` = 0, `cnt` = 0, FSM = IDLE.
  - Any pending request is discarded.

## Timing
- `busy` rises on the clock after an accepted `load`.
- DIV_P takes 32 cycles, DIV_H takes 40 cycles, plus one transition cycle each.
- P and H are ready 74 cycles after the load.
- Apply time is immediate when stopped; otherwise up to `period` further cycles.
- `err` asserts on the cycle after an invalid `load`.
- `period` updates on the same edge where `cnt` wraps to 0 under the new settings.
- `sign_out` lags `cnt` by one register stage.
- The first high phase of a new setting begins on the cycle after the apply edge.

## Configuration
- `SIG_GEN_SYNC_EN` defined:
  - Adds output port `sync` (out, 1), a registered one-cycle pulse aligned with `sign_out`'s rising position, i.e. `cnt` == 0.
  - `sync` resets to 0.
  - The scope uses it as an external trigger.
  - `sync` pulses every period, including when duty is 0 or 100.
- Undefined: the `sync` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `sig_gen_pkg` holds:
  - constants FREQ_W = 28, DUTY_W = 7, DUTY_MAX = 100, PROD_W = 40;
  - the FSM state enum (IDLE, DIV_P, DIV_H, ARM).
- Sub-module `seq_div`:
  - parameterised width, restoring divider, one quotient bit per clock;
  - start/done handshake, async active-low reset;
  - instantiated once and time-shared between the P and H computations.

## Test plan
- **Reset:** hold `rst` low mid-operation → `sign_out`, `busy`, `err` and `period` all 0. After release, the output stays low with no load.
- **1 MHz / 50 %:** `freq_set` = 1_000_000, `duty_set` = 50 →
  - `period` = 100 and `busy` falls;
  - `sign_out` alternates 50 high / 50 low, repeatedly.
- **Retune mid-period:** running 100/50, load 2_000_000 / 25 at `cnt` = 10 →
  - the old period completes in full;
  - the next period is 50 cycles with 12 high;
  - there is no runt pulse.
- **Rejects:**
  - `freq_set` = 0, `duty_set` = 101 and `freq_set` = 50_000_001 each give `err` = 1 with the output unchanged;
  - a following valid load clears `err`.
- **Extremes:**
  - 3 Hz / 33 % → `period` = 33_333_333, first high interval 10_999_999 cycles;
  - duty 0 → constant low; duty 100 → constant high.
- **Busy guard and sync:**
  - a second `load` while `busy` is high is ignored, and the first request's values are applied;
  - with `SIG_GEN_SYNC_EN`, `sync` pulses once per period at `cnt` == 0.

Source files
------------

// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared widths, FSM state type and request validation for sig_gen.
package sig_gen_pkg;

   localparam int FREQ_W   = 28;
   localparam int DUTY_W   = 7;
   localparam int DUTY_MAX = 100;
   localparam int PROD_W   = 40;
   localparam int LEN_W    = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV_P = 2'd1,
      DIV_H = 2'd2,
      ARM   = 2'd3
   } state_t;

   // A request is usable when the frequency is nonzero, at most half the
   // clock rate, and the duty cycle is a percentage.
   function automatic logic req_valid(input logic [FREQ_W-1:0] freq,
                                      input logic [DUTY_W-1:0] duty,
                                      input int unsigned       half_clk);
      logic ok;
      ok = (freq != {FREQ_W{1'b0}}) &&
           ({4'd0, freq} <= half_clk) &&
           (duty <= DUTY_W'(DUTY_MAX));
      return ok;
   endfunction

endpackage

// File: rtl/sig_gen_if.sv
// sig_gen_if: request/status bundle between a controller and sig_gen.
interface sig_gen_if #(parameter int CNT_W = 32);
   import sig_gen_pkg::*;

   logic [FREQ_W-1:0] freq_set;
   logic [DUTY_W-1:0] duty_set;
   logic              load;
   logic              busy;
   logic              err;
   logic [CNT_W-1:0]  period;

   modport master (output freq_set, duty_set, load, input busy, err, period);
   modport slave  (input freq_set, duty_set, load, output busy, err, period);

endinterface

// File: rtl/seq_div.sv
// seq_div: restoring divider, one quotient bit per clock. The iteration count
// is chosen per start so a short dividend does not pay for the full width:
// the dividend is left-aligned so its top 'len' bits are consumed.
module seq_div #(
   parameter int W     = 40,
   parameter int LEN_W = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [W-1:0]     dividend,
   input  logic [W-1:0]     divisor,
   output logic             done,
   output logic [W-1:0]     quotient
);

   logic [W-1:0]     rem;
   logic [W-1:0]     dvs;
   logic [LEN_W-1:0] count;
   logic [W:0]       rem_sh;
   logic [W:0]       rem_sub;

   // Trial subtraction of the divisor from the shifted partial remainder.
   always_comb begin
      rem_sh  = {rem, quotient[W-1]};
      rem_sub = rem_sh - {1'b0, dvs};
   end

   // Iteration state: load on start, then shift one quotient bit per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= {W{1'b0}};
         dvs      <= {W{1'b0}};
         quotient <= {W{1'b0}};
         count    <= {LEN_W{1'b0}};
         done     <= 1'b0;
      end else if (start) begin
         rem      <= {W{1'b0}};
         dvs      <= divisor;
         quotient <= dividend << (LEN_W'(W) - len);
         count    <= len;
         done     <= 1'b0;
      end else if (count != {LEN_W{1'b0}}) begin
         if (rem_sh >= {1'b0, dvs}) begin
            rem      <= rem_sub[W-1:0];
            quotient <= {quotient[W-2:0], 1'b1};
         end else begin
            rem      <= rem_sh[W-1:0];
            quotient <= {quotient[W-2:0], 1'b0};
         end
         count <= count - LEN_W'(1);
         done  <= (count == LEN_W'(1));
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/sig_gen.sv
// sig_gen: programmable square-wave generator. Converts a frequency/duty
// request into period and high-time counts with one shared divider and
// switches to the new setting only at a period boundary.
// Optional feature macro: SIG_GEN_SYNC_EN adds the one-cycle 'sync' output.
module sig_gen #(
   parameter int CLK_HZ = 100_000_000,
   parameter int CNT_W  = 32
) (
   input  logic      clk_100M,
   input  logic      rst,
   sig_gen_if.slave  bus,
   output logic      sign_out
`ifdef SIG_GEN_SYNC_EN
   ,
   output logic      sync
`endif
);
   import sig_gen_pkg::*;

   localparam int unsigned     HALF_CLK = CLK_HZ / 2;
   localparam logic [LEN_W-1:0] LEN_P   = 6'd32;
   localparam logic [LEN_W-1:0] LEN_H   = 6'd40;

   state_t              state;
   state_t              next_state;
   logic [DUTY_W-1:0]   duty_lat;
   logic [CNT_W-1:0]    p_new;
   logic [CNT_W-1:0]    h_new;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    high;
   logic [CNT_W-1:0]    period;
   logic                busy;
   logic                err;
   logic                req_ok;
   logic                wrap;
   logic                lat_p;
   logic                lat_h;
   logic                apply;
   logic                div_start;
   logic                div_done;
   logic [LEN_W-1:0]    div_len;
   logic [PROD_W-1:0]   div_dividend;
   logic [PROD_W-1:0]   div_divisor;
   logic [PROD_W-1:0]   div_q;

   assign req_ok     = req_valid(bus.freq_set, bus.duty_set, HALF_CLK);
   assign wrap       = (period != {CNT_W{1'b0}}) && (cnt == period - CNT_W'(1));
   assign bus.busy   = busy;
   assign bus.err    = err;
   assign bus.period = period;

   seq_div #(.W(PROD_W), .LEN_W(LEN_W)) u_div (
      .clk      (clk_100M),
      .rst_n    (rst),
      .start    (div_start),
      .len      (div_len),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .done     (div_done),
      .quotient (div_q)
   );

   // Next-state logic and divider sequencing: P first, then H from P * duty.
   always_comb begin
      next_state   = state;
      div_start    = 1'b0;
      div_len      = LEN_P;
      div_dividend = PROD_W'(CLK_HZ);
      div_divisor  = {{(PROD_W-FREQ_W){1'b0}}, bus.freq_set};
      lat_p        = 1'b0;
      lat_h        = 1'b0;
      apply        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load && req_ok) begin
               next_state = DIV_P;
               div_start  = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         DIV_P: begin
            if (div_done) begin
               next_state   = DIV_H;
               div_start    = 1'b1;
               div_len      = LEN_H;
               div_dividend = div_q * {{(PROD_W-DUTY_W){1'b0}}, duty_lat};
               div_divisor  = PROD_W'(DUTY_MAX);
               lat_p        = 1'b1;
            end else begin
               next_state = DIV_P;
            end
         end
         DIV_H: begin
            if (div_done) begin
               next_state = ARM;
               lat_h      = 1'b1;
            end else begin
               next_state = DIV_H;
            end
         end
         ARM: begin
            if ((period == {CNT_W{1'b0}}) || wrap) begin
               next_state = IDLE;
               apply      = 1'b1;
            end else begin
               next_state = ARM;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; busy covers every non-idle state.
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
      end
   end

   // Request capture: sticky error on rejects, duty kept for the H divide.
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         err      <= 1'b0;
         duty_lat <= {DUTY_W{1'b0}};
      end else if ((state == IDLE) && bus.load) begin
         err <= !req_ok;
         if (req_ok) begin
            duty_lat <= bus.duty_set;
         end
      end
   end

   // Computed settings waiting to be applied at the next period boundary.
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         p_new <= {CNT_W{1'b0}};
         h_new <= {CNT_W{1'b0}};
      end else begin
         if (lat_p) begin
            p_new <= CNT_W'(div_q);
         end
         if (lat_h) begin
            h_new <= CNT_W'(div_q);
         end
      end
   end

   // Period counter; new settings load exactly where the count wraps to 0.
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         cnt    <= {CNT_W{1'b0}};
         period <= {CNT_W{1'b0}};
         high   <= {CNT_W{1'b0}};
      end else if (apply) begin
         cnt    <= {CNT_W{1'b0}};
         period <= p_new;
         high   <= h_new;
      end else if (wrap) begin
         cnt <= {CNT_W{1'b0}};
      end else if (period != {CNT_W{1'b0}}) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         cnt <= {CNT_W{1'b0}};
      end
   end

   // Registered square wave; high while the count is inside the high time.
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         sign_out <= 1'b0;
      end else begin
         sign_out <= (cnt < high);
      end
   end

`ifdef SIG_GEN_SYNC_EN
   // Trigger pulse at the start of every running period.
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         sync <= 1'b0;
      end else begin
         sync <= (period != {CNT_W{1'b0}}) && (cnt == {CNT_W{1'b0}});
      end
   end
`endif

endmodule

// File: tb/tb_sig_gen.sv
// tb_sig_gen: randomized self-checking bench for sig_gen with a frequency/duty
// reference model (period = CLK/f, high = period*duty/100, waveform k mod P).
module tb_sig_gen;
   import sig_gen_pkg::*;

   localparam int CLK_HZ = 100_000_000;
   localparam int CNT_W  = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sign_out;
`ifdef SIG_GEN_SYNC_EN
   logic sync;
   logic wave_sync[$];
`endif
   int   total = 0;
   int   bad   = 0;
   logic wave[$];
   longint cur_p;

   sig_gen_if #(.CNT_W(CNT_W)) bus();

   sig_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
      .clk_100M (clk),
      .rst      (rst),
      .bus      (bus),
      .sign_out (sign_out)
`ifdef SIG_GEN_SYNC_EN
      ,
      .sync     (sync)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   function automatic longint exp_p(longint f);
      return CLK_HZ / f;
   endfunction

   function automatic longint exp_h(longint p, longint d);
      return (p * d) / 100;
   endfunction

   function automatic int count_bad(longint p, longint h);
      int n = 0;
      foreach (wave[k]) begin
         if (wave[k] !== (((k % p) < h) ? 1'b1 : 1'b0)) n++;
      end
      return n;
   endfunction

   task automatic do_load(input int f, input int d);
      @(negedge clk);
      bus.freq_set = FREQ_W'(f);
      bus.duty_set = DUTY_W'(d);
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < limit; i++) begin
         if (bus.busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         n++;
         @(negedge clk);
      end
   endtask

   task automatic sample_wave(input int n);
      wave.delete();
`ifdef SIG_GEN_SYNC_EN
      wave_sync.delete();
`endif
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         wave.push_back(sign_out);
`ifdef SIG_GEN_SYNC_EN
         wave_sync.push_back(sync);
`endif
      end
   endtask

   task automatic test_reset;
      bus.freq_set = '0;
      bus.duty_set = '0;
      bus.load     = 1'b0;
      rst          = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (sign_out !== 1'b0) begin bad++; $display("FAIL reset_sign: got %b want 0", sign_out); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
      total++; if (bus.period !== 32'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", bus.period); end
      rst = 1'b1;
      sample_wave(50);
      total++; if (count_bad(1, 0) != 0) begin bad++; $display("FAIL reset_idle_low: %0d high samples want 0", count_bad(1, 0)); end
      cur_p = 0;
   endtask

   task automatic test_basic;
      bit ok; int n;
      do_load(1_000_000, 50);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise: got %b want 1", bus.busy); end
      wait_idle(300, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL basic_timeout: busy still high after %0d cycles", n); end
      total++; if (n < 74 || n > 76) begin bad++; $display("FAIL basic_latency: busy %0d cycles want 74..76", n); end
      total++; if (bus.period !== 32'(exp_p(1_000_000))) begin bad++; $display("FAIL basic_period: got %0d want %0d", bus.period, exp_p(1_000_000)); end
      sample_wave(300);
      total++; if (count_bad(100, 50) != 0) begin bad++; $display("FAIL basic_wave: %0d wrong samples want 0", count_bad(100, 50)); end
      cur_p = 100;
   endtask

   task automatic test_retune;
      bit ok; int n; int errs;
      logic e;
      do_load(1_000_000, 50);
      wait_idle(300, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL retune_setup: busy stuck %0d cycles", n); end
      wave.delete();
      for (int j = 0; j < 250; j++) begin
         @(negedge clk);
         wave.push_back(sign_out);
         if (j == 9) begin
            bus.freq_set = FREQ_W'(2_000_000);
            bus.duty_set = DUTY_W'(25);
            bus.load     = 1'b1;
         end else begin
            bus.load = 1'b0;
         end
      end
      errs = 0;
      foreach (wave[j]) begin
         if (j < 100) e = ((j % 100) < 50) ? 1'b1 : 1'b0;
         else         e = (((j - 100) % 50) < exp_h(50, 25)) ? 1'b1 : 1'b0;
         if (wave[j] !== e) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL retune_wave: %0d wrong samples want 0", errs); end
      total++; if (bus.period !== 32'd50) begin bad++; $display("FAIL retune_period: got %0d want 50", bus.period); end
      cur_p = 50;
   endtask

   task automatic test_rejects;
      int fs[3] = '{0, 1_000_000, 50_000_001};
      int ds[3] = '{50, 101, 50};
      bit ok; int n; int highs;
      for (int i = 0; i < 3; i++) begin
         do_load(fs[i], ds[i]);
         total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL reject%0d_err: got %b want 1", i, bus.err); end
         total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reject%0d_busy: got %b want 0", i, bus.busy); end
         sample_wave(100);
         highs = 0;
         foreach (wave[k]) if (wave[k] === 1'b1) highs++;
         total++; if (highs != 2 * exp_h(50, 25)) begin bad++; $display("FAIL reject%0d_wave: %0d highs want %0d", i, highs, 2 * exp_h(50, 25)); end
         total++; if (bus.period !== 32'(cur_p)) begin bad++; $display("FAIL reject%0d_period: got %0d want %0d", i, bus.period, cur_p); end
      end
      do_load(2_000_000, 80);
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reject_clear: err %b want 0", bus.err); end
      wait_idle(300, ok, n);
      sample_wave(150);
      total++; if (count_bad(50, exp_h(50, 80)) != 0) begin bad++; $display("FAIL reject_valid_wave: %0d wrong samples", count_bad(50, exp_h(50, 80))); end
   endtask

   task automatic test_busy_guard;
      bit ok; int n;
      do_load(4_000_000, 75);
      repeat (5) @(negedge clk);
      bus.freq_set = FREQ_W'(10_000_000);
      bus.duty_set = DUTY_W'(10);
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
      wait_idle(300, ok, n);
      total++; if (!ok) begin bad++; $display("FAIL guard_timeout: busy stuck %0d", n); end
      total++; if (bus.period !== 32'(exp_p(4_000_000))) begin bad++; $display("FAIL guard_period: got %0d want %0d", bus.period, exp_p(4_000_000)); end
      sample_wave(100);
      total++; if (count_bad(25, exp_h(25, 75)) != 0) begin bad++; $display("FAIL guard_wave: %0d wrong samples", count_bad(25, exp_h(25, 75))); end
`ifdef SIG_GEN_SYNC_EN
      begin
         int se = 0;
         foreach (wave_sync[k]) if (wave_sync[k] !== (((k % 25) == 0) ? 1'b1 : 1'b0)) se++;
         total++; if (se != 0) begin bad++; $display("FAIL sync_pulses: %0d wrong samples want 0", se); end
      end
`endif
      cur_p = 25;
   endtask

   task automatic test_random;
      bit ok; int n; int f; int d; bit valid;
      longint p; longint h;
      for (int i = 0; i < 8; i++) begin
         valid = ($urandom_range(3, 0) != 0);
         f = $urandom_range(50_000_000, 500_000);
         d = valid ? $urandom_range(100, 0) : $urandom_range(127, 101);
         do_load(f, d);
         total++; if (bus.err !== !valid) begin bad++; $display("FAIL rand%0d_err: got %b want %b (f=%0d d=%0d)", i, bus.err, !valid, f, d); end
         if (valid) begin
            p = exp_p(f);
            h = exp_h(p, d);
            wait_idle(400, ok, n);
            total++; if (bus.period !== 32'(p)) begin bad++; $display("FAIL rand%0d_period: got %0d want %0d", i, bus.period, p); end
            sample_wave(int'(2 * p + 3));
            total++; if (count_bad(p, h) != 0) begin bad++; $display("FAIL rand%0d_wave: %0d wrong (P=%0d H=%0d)", i, count_bad(p, h), p, h); end
            cur_p = p;
         end else begin
            repeat (3) @(negedge clk);
            total++; if (bus.period !== 32'(cur_p)) begin bad++; $display("FAIL rand%0d_keep: got %0d want %0d", i, bus.period, cur_p); end
         end
      end
   endtask

   task automatic test_extremes;
      int fs[4] = '{1_000_000, 1_000_000, 50_000_000, 50_000_000};
      int ds[4] = '{0, 100, 50, 10};
      bit ok; int n; longint p; longint h;
      for (int i = 0; i < 4; i++) begin
         p = exp_p(fs[i]);
         h = exp_h(p, ds[i]);
         do_load(fs[i], ds[i]);
         wait_idle(400, ok, n);
         total++; if (bus.period !== 32'(p)) begin bad++; $display("FAIL ext%0d_period: got %0d want %0d", i, bus.period, p); end
         sample_wave(200);
         total++; if (count_bad(p, h) != 0) begin bad++; $display("FAIL ext%0d_wave: %0d wrong (P=%0d H=%0d)", i, count_bad(p, h), p, h); end
`ifdef SIG_GEN_SYNC_EN
         begin
            int se = 0;
            foreach (wave_sync[k]) if (wave_sync[k] !== (((k % p) == 0) ? 1'b1 : 1'b0)) se++;
            total++; if (se != 0) begin bad++; $display("FAIL ext%0d_sync: %0d wrong samples", i, se); end
         end
`endif
      end
      p = exp_p(3);
      h = exp_h(p, 33);
      do_load(3, 33);
      wait_idle(400, ok, n);
      total++; if (bus.period !== 32'(p)) begin bad++; $display("FAIL slow_period: got %0d want %0d", bus.period, p); end
      total++; if (dut.high !== 32'(h)) begin bad++; $display("FAIL slow_high: got %0d want %0d", dut.high, h); end
      sample_wave(2000);
      total++; if (count_bad(p, h) != 0) begin bad++; $display("FAIL slow_wave: %0d wrong samples", count_bad(p, h)); end
   endtask

   task automatic test_reset_mid;
      do_load(1_000_000, 50);
      repeat (20) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++; if (sign_out !== 1'b0) begin bad++; $display("FAIL mid_sign: got %b want 0", sign_out); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
      total++; if (bus.period !== 32'd0) begin bad++; $display("FAIL mid_period: got %0d want 0", bus.period); end
      @(negedge clk);
      rst = 1'b1;
      sample_wave(200);
      total++; if (count_bad(1, 0) != 0) begin bad++; $display("FAIL mid_after_low: %0d high samples", count_bad(1, 0)); end
      total++; if (bus.period !== 32'd0) begin bad++; $display("FAIL mid_after_period: got %0d want 0", bus.period); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_after_busy: got %b want 0", bus.busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_retune();
      test_rejects();
      test_busy_guard();
      test_random();
      test_extremes();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
